// File: rtl/bcd_counter_ndigit_if.sv
// Control and status bundle for bcd_counter_ndigit: master drives the
// controls and load value, slave returns the packed count and pulse flags.
interface bcd_counter_ndigit_if #(parameter int DIGITS = 3);
   logic                  clear;
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic                  en;
   logic                  up;
   logic [4*DIGITS-1:0]   q;
   logic                  overflow;
   logic                  load_err;

   modport master (output clear, load, load_val, en, up,
                   input  q, overflow, load_err);
   modport slave  (input  clear, load, load_val, en, up,
                   output q, overflow, load_err);
endinterface

// File: rtl/bcd_counter_ndigit.sv
// DIGITS-decade BCD up/down counter with synchronous clear/load and wrap pulse.
// Define BCD_COUNTER_SATURATE_EN to hold at the end values instead of wrapping.

// One decade: steps when step_i is set and reports a carry/borrow to the next.
module bcd_digit_step (
   input  logic [3:0] dig_i,
   input  logic       up_i,
   input  logic       step_i,
   output logic [3:0] dig_o,
   output logic       carry_o
);
   always_comb begin
      dig_o   = dig_i;
      carry_o = step_i & (up_i ? (dig_i == 4'd9) : (dig_i == 4'd0));
      if (step_i) begin
         if (up_i) dig_o = (dig_i == 4'd9) ? 4'd0 : dig_i + 4'd1;
         else      dig_o = (dig_i == 4'd0) ? 4'd9 : dig_i - 4'd1;
      end
   end
endmodule

module bcd_counter_ndigit #(
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   bcd_counter_ndigit_if.slave   bus
);
   logic [DIGITS-1:0][3:0] q_q, q_d, cnt_nxt, ld_nxt;
   logic [DIGITS:0]        step;
   logic [DIGITS-1:0]      bad;
   logic                   ovf_q, ovf_d, lerr_q, lerr_d;

   // step[i] set means every lower digit sits at the wrap value for this direction.
   assign step[0] = 1'b1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      bcd_digit_step u_step (
         .dig_i   (q_q[g]),
         .up_i    (bus.up),
         .step_i  (step[g]),
         .dig_o   (cnt_nxt[g]),
         .carry_o (step[g+1])
      );
      assign bad[g]    = (bus.load_val[g*4 +: 4] > 4'd9);
      assign ld_nxt[g] = bad[g] ? 4'd9 : bus.load_val[g*4 +: 4];
   end

   always_comb begin
      q_d    = q_q;
      ovf_d  = 1'b0;
      lerr_d = 1'b0;
      if (bus.clear) begin
         q_d = '0;
      end else if (bus.load) begin
         q_d    = ld_nxt;
         lerr_d = |bad;
      end else if (bus.en) begin
         ovf_d = step[DIGITS];
`ifdef BCD_COUNTER_SATURATE_EN
         if (!step[DIGITS]) q_d = cnt_nxt;
`else
         q_d = cnt_nxt;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_q    <= '0;
         ovf_q  <= 1'b0;
         lerr_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         ovf_q  <= ovf_d;
         lerr_q <= lerr_d;
      end
   end

   assign bus.q        = q_q;
   assign bus.overflow = ovf_q;
   assign bus.load_err = lerr_q;
endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Randomised and directed bench for bcd_counter_ndigit (3-digit and 1-digit
// instances) against an integer-valued reference model.
module tb_bcd_counter_ndigit;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   bcd_counter_ndigit_if #(.DIGITS(3)) b3 ();
   bcd_counter_ndigit_if #(.DIGITS(1)) b1 ();

   bcd_counter_ndigit #(.DIGITS(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(b3.slave));
   bcd_counter_ndigit #(.DIGITS(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(b1.slave));

   int pass_cnt = 0;
   int total_cnt = 0;

   // model state, held as plain integers
   int m3_val = 0; bit m3_ovf = 0; bit m3_lerr = 0;
   int m1_val = 0; bit m1_ovf = 0; bit m1_lerr = 0;

`ifdef BCD_COUNTER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   function automatic logic [31:0] to_bcd(input int v, input int nd);
      logic [31:0] r = '0;
      int x = v;
      for (int i = 0; i < nd; i++) begin
         r[i*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic void mstep(input int nd, input int v, input bit clr, input bit ld,
                                 input logic [31:0] ldv, input bit e, input bit u,
                                 output int nv, output bit ov, output bit le);
      int mx = 1;
      for (int i = 0; i < nd; i++) mx = mx * 10;
      mx = mx - 1;
      nv = v; ov = 1'b0; le = 1'b0;
      if (clr) nv = 0;
      else if (ld) begin
         nv = 0;
         for (int i = nd - 1; i >= 0; i--) begin
            int d;
            d = int'(ldv[i*4 +: 4]);
            if (d > 9) begin d = 9; le = 1'b1; end
            nv = nv * 10 + d;
         end
      end else if (e) begin
         if (u) begin
            if (v == mx) begin ov = 1'b1; nv = SAT ? mx : 0; end
            else nv = v + 1;
         end else begin
            if (v == 0) begin ov = 1'b1; nv = SAT ? 0 : mx; end
            else nv = v - 1;
         end
      end
   endfunction

   task automatic drive3(input bit clr, input bit ld, input logic [11:0] ldv, input bit e, input bit u);
      b3.clear = clr; b3.load = ld; b3.load_val = ldv; b3.en = e; b3.up = u;
   endtask

   // advance one edge, updating both models from the inputs seen at that edge
   task automatic tick();
      int nv; bit ov, le;
      mstep(3, m3_val, b3.clear, b3.load, {20'd0, b3.load_val}, b3.en, b3.up, nv, ov, le);
      m3_val = nv; m3_ovf = ov; m3_lerr = le;
      mstep(1, m1_val, b1.clear, b1.load, {28'd0, b1.load_val}, b1.en, b1.up, nv, ov, le);
      m1_val = nv; m1_ovf = ov; m1_lerr = le;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [31:0] e;
      drive3(0, 1, 12'h347, 0, 0);
      tick();
      total_cnt++;
      if (b3.q !== 12'h347) $display("FAIL reset_preload q=%h exp=347", b3.q); else pass_cnt++;
      drive3(0, 0, 12'h000, 1, 1);
      #2 reset_n = 1'b0;
      #1;
      m3_val = 0; m3_ovf = 0; m3_lerr = 0; m1_val = 0; m1_ovf = 0; m1_lerr = 0;
      total_cnt++;
      if (b3.q !== 12'h000 || b3.overflow !== 1'b0 || b3.load_err !== 1'b0)
         $display("FAIL reset_async q=%h ov=%b le=%b exp q=000 ov=0 le=0", b3.q, b3.overflow, b3.load_err);
      else pass_cnt++;
      reset_n = 1'b1;
      tick();
      e = to_bcd(m3_val, 3);
      total_cnt++;
      if (b3.q !== 12'h001 || b3.q !== e[11:0] || b3.overflow !== 1'b0)
         $display("FAIL reset_first_count q=%h ov=%b exp q=001 ov=0", b3.q, b3.overflow);
      else pass_cnt++;
   endtask

   task automatic test_carry();
      logic [11:0] exp_q [2] = '{12'h100, 12'h101};
      drive3(0, 1, 12'h099, 0, 0);
      tick();
      drive3(0, 0, 12'h000, 1, 1);
      for (int i = 0; i < 2; i++) begin
         tick();
         total_cnt++;
         if (b3.q !== exp_q[i] || b3.overflow !== 1'b0)
            $display("FAIL carry_chain[%0d] q=%h ov=%b exp q=%h ov=0", i, b3.q, b3.overflow, exp_q[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_wrap_up();
      logic [11:0] exp_q [3];
      bit          exp_o [3];
      if (SAT) begin exp_q = '{12'h999, 12'h999, 12'h999}; exp_o = '{0, 1, 1}; end
      else     begin exp_q = '{12'h999, 12'h000, 12'h001}; exp_o = '{0, 1, 0}; end
      drive3(0, 1, 12'h998, 0, 0);
      tick();
      drive3(0, 0, 12'h000, 1, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         total_cnt++;
         if (b3.q !== exp_q[i] || b3.overflow !== exp_o[i])
            $display("FAIL wrap_up[%0d] q=%h ov=%b exp q=%h ov=%b", i, b3.q, b3.overflow, exp_q[i], exp_o[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_wrap_down();
      logic [31:0] e;
      drive3(1, 0, 12'h000, 0, 0);
      tick();
      drive3(0, 0, 12'h000, 1, 0);
      for (int i = 0; i < 2; i++) begin
         tick();
         e = to_bcd(m3_val, 3);
         total_cnt++;
         if (b3.q !== e[11:0] || b3.overflow !== m3_ovf || b3.load_err !== 1'b0)
            $display("FAIL wrap_down[%0d] q=%h ov=%b exp q=%h ov=%b", i, b3.q, b3.overflow, e[11:0], m3_ovf);
         else pass_cnt++;
      end
      total_cnt++;
      if (!SAT && b3.q !== 12'h998) $display("FAIL wrap_down_final q=%h exp=998", b3.q);
      else if (SAT && b3.q !== 12'h000) $display("FAIL wrap_down_final q=%h exp=000", b3.q);
      else pass_cnt++;
   endtask

   task automatic test_priority_clamp();
      drive3(0, 1, 12'h456, 0, 0);
      tick();
      drive3(1, 1, 12'h777, 1, 1);
      tick();
      total_cnt++;
      if (b3.q !== 12'h000 || b3.overflow !== 1'b0 || b3.load_err !== 1'b0)
         $display("FAIL priority q=%h ov=%b le=%b exp q=000 ov=0 le=0", b3.q, b3.overflow, b3.load_err);
      else pass_cnt++;
      drive3(0, 1, 12'h5C3, 1, 0);
      tick();
      total_cnt++;
      if (b3.q !== 12'h593 || b3.load_err !== 1'b1 || b3.overflow !== 1'b0)
         $display("FAIL clamp q=%h le=%b exp q=593 le=1", b3.q, b3.load_err);
      else pass_cnt++;
      drive3(0, 0, 12'h000, 0, 0);
      tick();
      total_cnt++;
      if (b3.q !== 12'h593 || b3.load_err !== 1'b0)
         $display("FAIL clamp_pulse_end q=%h le=%b exp q=593 le=0", b3.q, b3.load_err);
      else pass_cnt++;
   endtask

   task automatic test_dir_toggle();
      logic [3:0] exp_q [3];
      bit         exp_o [3];
      bit         dirs  [3] = '{1, 0, 0};
      if (SAT) begin exp_q = '{4'd9, 4'd8, 4'd7}; exp_o = '{1, 0, 0}; end
      else     begin exp_q = '{4'd0, 4'd9, 4'd8}; exp_o = '{1, 1, 0}; end
      b1.clear = 0; b1.load = 1; b1.load_val = 4'h9; b1.en = 0; b1.up = 0;
      tick();
      b1.load = 0; b1.en = 1;
      for (int i = 0; i < 3; i++) begin
         b1.up = dirs[i];
         tick();
         total_cnt++;
         if (b1.q !== exp_q[i] || b1.overflow !== exp_o[i] || b1.q !== 4'(m1_val))
            $display("FAIL dir_toggle[%0d] q=%h ov=%b exp q=%h ov=%b", i, b1.q, b1.overflow, exp_q[i], exp_o[i]);
         else pass_cnt++;
      end
      b1.en = 0;
   endtask

   task automatic test_random();
      logic [31:0] e;
      for (int i = 0; i < 400; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         drive3(r < 3, (r >= 3 && r < 10), 12'($urandom), ($urandom_range(0, 9) != 0), 1'($urandom));
         // bias towards the ends of the range to exercise wraps
         if (r >= 10 && r < 14) begin b3.load = 1; b3.load_val = (r[0]) ? 12'h999 : 12'h001; end
         tick();
         e = to_bcd(m3_val, 3);
         total_cnt++;
         if (b3.q !== e[11:0] || b3.overflow !== m3_ovf || b3.load_err !== m3_lerr)
            $display("FAIL random[%0d] q=%h ov=%b le=%b exp q=%h ov=%b le=%b",
                     i, b3.q, b3.overflow, b3.load_err, e[11:0], m3_ovf, m3_lerr);
         else pass_cnt++;
      end
      drive3(0, 0, 12'h000, 0, 0);
   endtask

   initial begin
      drive3(0, 0, 12'h000, 0, 0);
      b1.clear = 0; b1.load = 0; b1.load_val = 4'h0; b1.en = 0; b1.up = 0;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if (b3.q !== 12'h000 || b3.overflow !== 1'b0 || b3.load_err !== 1'b0 || b1.q !== 4'h0)
         $display("FAIL reset_state q3=%h q1=%h ov=%b le=%b exp all zero", b3.q, b1.q, b3.overflow, b3.load_err);
      else pass_cnt++;
      reset_n = 1'b1;
      test_reset();
      test_carry();
      test_wrap_up();
      test_wrap_down();
      test_priority_clamp();
      test_dir_toggle();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
